// File: rtl/cnn_tile_sched_pkg.sv
// rtl/cnn_tile_sched_pkg.sv - shared state encoding and default widths for the tile scheduler
package cnn_tile_sched_pkg;

  localparam int DEF_KERNEL_WIDTH = 4;
  localparam int DEF_KERNEL_SIZE  = 3;
  localparam int DEF_TILE_W       = 16;
  localparam int DEF_CNT_W        = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN,
    ST_FINAL,
    ST_DONE
  } sched_state_t;

endpackage

// File: rtl/cnn_tile_sched_sat_counter.sv
// rtl/cnn_tile_sched_sat_counter.sv - up counter with synchronous clear that holds at all-ones
module sat_counter #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/cnn_tile_sched.sv
// rtl/cnn_tile_sched.sv - per-layer tile sequencer for the CNN window buffer
module cnn_tile_sched
  import cnn_tile_sched_pkg::*;
#(
  parameter int KERNEL_WIDTH = DEF_KERNEL_WIDTH,
  parameter int KERNEL_SIZE  = DEF_KERNEL_SIZE,
  parameter int TILE_W       = DEF_TILE_W,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [KERNEL_WIDTH-1:0] cfg_kernel_w,
  input  logic [KERNEL_WIDTH-1:0] cfg_kernel_h,
  input  logic [TILE_W-1:0]       cfg_tiles,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic                    cfg_err,
  output logic [TILE_W-1:0]       tile_idx,
  output logic [CNT_W-1:0]        tile_win_cnt,
  output logic [CNT_W-1:0]        layer_win_cnt,
  output logic                    buf_req,
  output logic                    buf_req_final,
  output logic [KERNEL_WIDTH-1:0] buf_kernel_width,
  output logic [KERNEL_WIDTH-1:0] buf_kernel_height,
  input  logic                    buf_window_valid,
  input  logic                    buf_window_finish,
  output logic                    buf_window_stall,
  input  logic                    pe_ready
);

  sched_state_t state, state_nx;

  logic [KERNEL_WIDTH-1:0] kw_q, kh_q;
  logic [TILE_W-1:0]       tiles_q, tile_idx_q;
  logic [TILE_W:0]         tile_nx;
  logic                    drain_armed, abort_pend, aborted_q, cfg_err_q;
  logic                    cfg_bad, more_tiles, final_abort, win_acc;
  logic                    latch_cfg, layer_clr, tile_adv;

  assign cfg_bad = (cfg_kernel_w == '0) || (cfg_kernel_w > KERNEL_WIDTH'(KERNEL_SIZE)) ||
                   (cfg_kernel_h == '0) || (cfg_kernel_h > KERNEL_WIDTH'(KERNEL_SIZE));

  assign tile_nx     = {1'b0, tile_idx_q} + {{TILE_W{1'b0}}, 1'b1};
  assign more_tiles  = tile_nx < {1'b0, tiles_q};
  assign final_abort = abort || abort_pend;
  assign win_acc     = buf_window_valid && pe_ready && ((state == ST_RUN) || (state == ST_DRAIN));

  always_comb begin
    state_nx  = state;
    latch_cfg = 1'b0;
    layer_clr = 1'b0;
    tile_adv  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !cfg_bad) begin
          latch_cfg = 1'b1;
          if (cfg_tiles == '0) begin
            state_nx = ST_DONE;
          end else begin
            layer_clr = 1'b1;
            state_nx  = ST_LOAD;
          end
        end
      end
      ST_LOAD:  state_nx = abort ? ST_FINAL : ST_RUN;
      ST_RUN: begin
        if (abort)                  state_nx = ST_FINAL;
        else if (buf_window_finish) state_nx = ST_DRAIN;
      end
      // the first DRAIN cycle is skipped: the buffer's valid is registered one cycle behind finish
      ST_DRAIN: begin
        if (abort || (drain_armed && (!buf_window_valid || pe_ready))) state_nx = ST_FINAL;
      end
      ST_FINAL: begin
        if (final_abort) begin
          state_nx = ST_IDLE;
        end else if (more_tiles) begin
          tile_adv = 1'b1;
          state_nx = ST_LOAD;
        end else begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      kw_q        <= {{(KERNEL_WIDTH-1){1'b0}}, 1'b1};
      kh_q        <= {{(KERNEL_WIDTH-1){1'b0}}, 1'b1};
      tiles_q     <= '0;
      tile_idx_q  <= '0;
      drain_armed <= 1'b0;
      abort_pend  <= 1'b0;
      aborted_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state       <= state_nx;
      drain_armed <= (state == ST_DRAIN);
      cfg_err_q   <= (state == ST_IDLE) && start && cfg_bad;
      aborted_q   <= (state == ST_FINAL) && final_abort;
      if (latch_cfg) begin
        kw_q    <= cfg_kernel_w;
        kh_q    <= cfg_kernel_h;
        tiles_q <= cfg_tiles;
      end
      if (layer_clr)     tile_idx_q <= '0;
      else if (tile_adv) tile_idx_q <= tile_nx[TILE_W-1:0];
      // abort must survive into FINAL so the buffer is still returned to idle first
      if (abort && ((state == ST_LOAD) || (state == ST_RUN) || (state == ST_DRAIN))) abort_pend <= 1'b1;
      else if (state_nx == ST_IDLE)                                                  abort_pend <= 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) u_tile_cnt (
    .clk (clk),
    .rst (rst),
    .clr (layer_clr || tile_adv),
    .inc (win_acc),
    .cnt (tile_win_cnt)
  );

  sat_counter #(.W(CNT_W)) u_layer_cnt (
    .clk (clk),
    .rst (rst),
    .clr (layer_clr),
    .inc (win_acc),
    .cnt (layer_win_cnt)
  );

  assign busy              = (state != ST_IDLE);
  assign done              = (state == ST_DONE);
  assign aborted           = aborted_q;
  assign cfg_err           = cfg_err_q;
  assign tile_idx          = tile_idx_q;
  assign buf_req           = (state == ST_LOAD);
  assign buf_req_final     = (state == ST_FINAL);
  assign buf_kernel_width  = kw_q;
  assign buf_kernel_height = kh_q;
  assign buf_window_stall  = ~pe_ready;

endmodule

// File: doc/cnn_tile_sched.md
# cnn_tile_sched

Tile scheduler for the CNN window buffer. Latches a layer configuration (kernel width/height, tile count) on a start handshake. Sequences the buffer through one req … req_final episode per input tile and gates its window output against PE back-pressure. Counts accepted windows per tile and per layer, then signals layer completion to the host-side controller.

## Interface
Parameters:
- KERNEL_WIDTH, 4: width of kernel-dimension fields.
- KERNEL_SIZE, 3: maximum legal kernel width/height.
- TILE_W, 16: width of tile count and tile index.
- CNT_W, 20: width of window counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  start request; sampled only in IDLE.
- cfg_kernel_w  in  KERNEL_WIDTH  kernel width for the layer.
- cfg_kernel_h  in  KERNEL_WIDTH  kernel height for the layer.
- cfg_tiles  in  TILE_W  number of tiles in the layer.
- abort  in  1  terminate the current layer.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when the layer completes normally.
- aborted  out  1  one-cycle pulse when the layer ends via abort.
- cfg_err  out  1  one-cycle pulse when start is rejected.
- tile_idx  out  TILE_W  index of the current tile.
- tile_win_cnt  out  CNT_W  windows accepted in the current tile.
- layer_win_cnt  out  CNT_W  windows accepted in the layer.
- buf_req  out  1  buffer start pulse.
- buf_req_final  out  1  buffer finish pulse.
- buf_kernel_width  out  KERNEL_WIDTH  latched kernel width.
- buf_kernel_height  out  KERNEL_WIDTH  latched kernel height.
- buf_window_valid  in  1  buffer window valid.
- buf_window_finish  in  1  buffer has issued its last window request.
- buf_window_stall  out  1  stall to buffer; equals ~pe_ready.
- pe_ready  in  1  downstream PE accepts a window.

## Operation
- States:
  - IDLE: waiting for start.
  - LOAD: buf_req=1 for exactly one cycle.
  - RUN: waiting for buf_window_finish.
  - DRAIN: waiting for the in-flight window to be accepted.
  - FINAL: buf_req_final=1 for exactly one cycle.
  - DONE: done=1 for one cycle.
- Start acceptance (IDLE & start):
  - cfg_kernel_w or cfg_kernel_h equal to 0 or greater than KERNEL_SIZE → cfg_err pulse, remain in IDLE, nothing latched.
  - cfg_tiles == 0 → latch the configuration, go directly to DONE.
  - Otherwise → latch the configuration, clear tile_idx and both counters, go to LOAD.
- Transitions:
  - LOAD → RUN.
  - RUN & buf_window_finish → DRAIN.
  - DRAIN → FINAL on the first cycle, counted from the second DRAIN cycle onward, in which (~buf_window_valid | pe_ready). The minimum of 2 DRAIN cycles covers the buffer's registered valid.
  - FINAL → LOAD if tile_idx+1 < tiles (tile_idx increments and tile_win_cnt clears on this edge); otherwise → DONE.
  - DONE → IDLE.
- Window acceptance = buf_window_valid & pe_ready, counted in RUN and DRAIN only. Counters saturate at all-ones and never wrap.
- Abort:
  - In LOAD, RUN or DRAIN → FINAL next cycle (the buffer must be returned to idle); after FINAL go to IDLE with an aborted pulse, no done.
  - In FINAL → same FINAL → IDLE path, with an aborted pulse.
  - In IDLE or DONE → ignored.
- buf_kernel_width/height are driven from latched registers and are stable from LOAD through FINAL. They change only on an accepted start.
- start asserted while busy is ignored.

## Timing
- Reset values: busy=0, done=0, aborted=0, cfg_err=0, buf_req=0, buf_req_final=0, tile_idx=0, tile_win_cnt=0, layer_win_cnt=0, buf_kernel_width=1, buf_kernel_height=1.
- Reset mid-layer returns to IDLE in one cycle with no final pulse; the buffer shares rst.
- Start sampled at edge t → LOAD in cycle t+1 (buf_req high), RUN from t+2.
- buf_window_finish seen at edge f → DRAIN from f+1. Earliest FINAL at f+3.
- Tile-to-tile gap: buf_req_final in cycle n → buf_req in cycle n+1.
- Last tile: FINAL in cycle n → done in cycle n+1 → busy low in cycle n+2.
- buf_window_stall is combinational from pe_ready; all other outputs are registered.

## Structure
- Shared package: state enum, KERNEL_SIZE, KERNEL_WIDTH, CNT_W defaults. These are shared with the buffer configuration header values.
- Single flat module. The saturating counter is a natural sub-module, sat_counter, instantiated twice.

## Test plan
- kw=kh=3, tiles=2, pe_ready=1, buffer model asserts finish 40 cycles after req and emits 36 windows per tile → two buf_req pulses, two buf_req_final pulses, layer_win_cnt=72, done once, busy low 2 cycles after the last final.
- cfg_kernel_w=0 (and separately cfg_kernel_w=4) → cfg_err pulse, busy stays 0, buf_req never asserted.
- tiles=0 → busy high for exactly 1 cycle, done pulse, buf_req never asserted.
- pe_ready low for 5 cycles spanning finish with valid held → buf_window_stall high for those 5 cycles, FINAL only after the held window is accepted, count includes it.
- abort in RUN of tile 1 of 3 → one buf_req_final the next cycle, aborted pulse, no done, tile_idx=1.
- rst asserted in DRAIN → all outputs at reset values the next cycle; a new start runs normally.
